// File: rtl/mips_hazard_scoreboard_pkg.sv
// Shared decode types and instruction classification helpers for the
// issue-stage register scoreboard.
package mips_hazard_scoreboard_pkg;

  typedef enum logic [3:0] {
    UNIMPLEMENTED_INSTRUCTION,
    NOP,
    ADDU,
    SUBU,
    AAND,
    OOR,
    SLT,
    SW,
    LW,
    ADDIU,
    ORI,
    LUI,
    BEQ,
    J,
    JAL,
    JR
  } Instruction;

  localparam int SB_REG_COUNT    = 32;
  localparam int SB_ALU_LATENCY  = 3;
  localparam int SB_LOAD_LATENCY = 4;
  localparam int SB_FORWARD      = 1;
  localparam int SB_STAT_W       = 32;

  function automatic logic WriteRegisterFile(input Instruction ins);
    case (ins)
      ADDU, SUBU, AAND, OOR, SLT, LW, ADDIU, ORI, LUI, JAL: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic LoadInstruction(input Instruction ins);
    return ins == LW;
  endfunction

  function automatic logic ReadsRs(input Instruction ins);
    case (ins)
      ADDU, SUBU, AAND, OOR, SLT, SW, LW, ADDIU, ORI, BEQ, JR: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic ReadsRt(input Instruction ins);
    case (ins)
      ADDU, SUBU, AAND, OOR, SLT, SW, BEQ: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_hazard_scoreboard_entry.sv
// One architectural register's in-flight write: cycles left until writeback
// and whether the producer is a load.
module mips_hazard_scoreboard_entry #(
  parameter int CNT_W = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_alloc,
  input  logic [CNT_W-1:0] i_alloc_lat,
  input  logic             i_alloc_load,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_is_load
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_load;

  // A fresh allocation wins over the background countdown.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_is_load <= 1'b0;
    end else if (i_alloc) begin
      r_cnt     <= i_alloc_lat;
      r_is_load <= i_alloc_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_load = r_is_load;

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Decode/issue interlock: tracks pending register writes and stalls the
// decoded instruction on RAW or WAW conflicts, counting stalled cycles.
module mips_hazard_scoreboard
  import mips_hazard_scoreboard_pkg::*;
#(
  parameter int REG_COUNT    = SB_REG_COUNT,
  parameter int ALU_LATENCY  = SB_ALU_LATENCY,
  parameter int LOAD_LATENCY = SB_LOAD_LATENCY,
  parameter int FORWARD      = SB_FORWARD,
  parameter int STAT_W       = SB_STAT_W
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_issue_valid,
  input  Instruction                     i_issue_ins,
  input  logic [$clog2(REG_COUNT)-1:0]   i_issue_rs,
  input  logic [$clog2(REG_COUNT)-1:0]   i_issue_rt,
  input  logic [$clog2(REG_COUNT)-1:0]   i_issue_dst,
  output logic                           o_stall,
  output logic [REG_COUNT-1:0]           o_busy_mask,
  output logic [$clog2(REG_COUNT+1)-1:0] o_pending_count,
  output logic [STAT_W-1:0]              o_stall_cycles
);

  localparam int REG_W  = $clog2(REG_COUNT);
  localparam int CNT_W  = $clog2(LOAD_LATENCY + 1);
  localparam int PEND_W = $clog2(REG_COUNT + 1);
  localparam logic [CNT_W-1:0] ALU_LAT  = CNT_W'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] LOAD_LAT = CNT_W'(LOAD_LATENCY);

  logic [CNT_W-1:0]     w_cnt [REG_COUNT];
  logic [REG_COUNT-1:0] w_is_load;
  logic [REG_COUNT-1:0] w_alloc;
  logic [REG_COUNT-1:0] w_busy;
  logic [REG_COUNT-1:0] w_busy_next;
  logic                 w_writes;
  logic                 w_is_ld;
  logic [CNT_W-1:0]     w_new_lat;
  logic                 w_rs_pending;
  logic                 w_rt_pending;
  logic                 w_raw_rs;
  logic                 w_raw_rt;
  logic                 w_waw;
  logic                 w_stall;
  logic                 w_accept;

  logic [PEND_W-1:0]    r_pending;
  logic [STAT_W-1:0]    r_stall_cycles;

  assign w_writes  = WriteRegisterFile(i_issue_ins) && (i_issue_dst != '0);
  assign w_is_ld   = LoadInstruction(i_issue_ins);
  assign w_new_lat = w_is_ld ? LOAD_LAT : ALU_LAT;

  // With bypassing only a load still in its first cycle cannot feed a consumer.
  assign w_rs_pending = (FORWARD != 0) ? (w_is_load[i_issue_rs] && (w_cnt[i_issue_rs] == LOAD_LAT))
                                       : (w_cnt[i_issue_rs] != '0);
  assign w_rt_pending = (FORWARD != 0) ? (w_is_load[i_issue_rt] && (w_cnt[i_issue_rt] == LOAD_LAT))
                                       : (w_cnt[i_issue_rt] != '0);

  assign w_raw_rs = ReadsRs(i_issue_ins) && (i_issue_rs != '0) && w_rs_pending;
  assign w_raw_rt = ReadsRt(i_issue_ins) && (i_issue_rt != '0) && w_rt_pending;
  assign w_waw    = w_writes && (w_cnt[i_issue_dst] >= w_new_lat);

  assign w_stall  = i_issue_valid && !i_reset && (w_raw_rs || w_raw_rt || w_waw);
  assign w_accept = i_issue_valid && !w_stall;

  assign w_cnt[0]     = '0;
  assign w_is_load[0] = 1'b0;
  assign w_alloc[0]   = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_entry
    assign w_alloc[r] = w_accept && w_writes && (i_issue_dst == REG_W'(r));

    mips_hazard_scoreboard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_alloc      (w_alloc[r]),
      .i_alloc_lat  (w_new_lat),
      .i_alloc_load (w_is_ld),
      .o_cnt        (w_cnt[r]),
      .o_is_load    (w_is_load[r])
    );
  end

  // Next-cycle occupancy lets the pending count stay in step with the counters.
  always_comb begin
    w_busy      = '0;
    w_busy_next = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      w_busy[r]      = (w_cnt[r] != '0);
      w_busy_next[r] = w_alloc[r] || (w_cnt[r] > CNT_W'(1));
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pending      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_pending <= PEND_W'($countones(w_busy_next));
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + STAT_W'(1);
      end
    end
  end

  assign o_stall         = w_stall;
  assign o_busy_mask     = w_busy;
  assign o_pending_count = r_pending;
  assign o_stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Drives two scoreboards (no bypass / 4-bit stats, and bypass / 32-bit stats)
// and checks them against a writeback-time model through an expectation queue.
module tb_mips_hazard_scoreboard;
  import mips_hazard_scoreboard_pkg::*;

  localparam int ALU_LAT  = 3;
  localparam int LOAD_LAT = 4;

  typedef struct {
    bit         valid;
    Instruction ins;
    int         rs;
    int         rt;
    int         dst;
  } instrT;

  typedef struct {
    int          d;
    bit          stall;
    logic [31:0] busy;
    int          pend;
    longint      sc;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld  [2];
  Instruction  insD [2];
  logic [4:0]  rsD  [2];
  logic [4:0]  rtD  [2];
  logic [4:0]  dstD [2];
  logic        stallD [2];
  logic [31:0] busyD  [2];
  logic [5:0]  pendD  [2];
  logic [3:0]  sc0;
  logic [31:0] sc1;

  int     nAssert = 0;
  int     nFail   = 0;
  int     now     = 0;
  int     wbCyc [2][32];
  bit     ldTag [2][32];
  longint scModel [2] = '{0, 0};
  longint scMax   [2] = '{15, 64'hFFFFFFFF};
  int     fwd     [2] = '{0, 1};
  instrT  prog0 [$];
  instrT  prog1 [$];
  expT    expQ  [$];

  always #5 clk = ~clk;

  mips_hazard_scoreboard #(.FORWARD(0), .STAT_W(4)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_issue_valid(vld[0]), .i_issue_ins(insD[0]),
    .i_issue_rs(rsD[0]), .i_issue_rt(rtD[0]), .i_issue_dst(dstD[0]),
    .o_stall(stallD[0]), .o_busy_mask(busyD[0]), .o_pending_count(pendD[0]),
    .o_stall_cycles(sc0)
  );

  mips_hazard_scoreboard #(.FORWARD(1), .STAT_W(32)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_issue_valid(vld[1]), .i_issue_ins(insD[1]),
    .i_issue_rs(rsD[1]), .i_issue_rt(rtD[1]), .i_issue_dst(dstD[1]),
    .o_stall(stallD[1]), .o_busy_mask(busyD[1]), .o_pending_count(pendD[1]),
    .o_stall_cycles(sc1)
  );

  function automatic bit tbWrites(input Instruction ins);
    return ins inside {ADDU, SUBU, AAND, OOR, SLT, LW, ADDIU, ORI, LUI, JAL};
  endfunction

  function automatic bit tbReadsRs(input Instruction ins);
    return ins inside {ADDU, SUBU, AAND, OOR, SLT, SW, LW, ADDIU, ORI, BEQ, JR};
  endfunction

  function automatic bit tbReadsRt(input Instruction ins);
    return ins inside {ADDU, SUBU, AAND, OOR, SLT, SW, BEQ};
  endfunction

  function automatic int remaining(input int d, input int r);
    return (wbCyc[d][r] > now) ? wbCyc[d][r] - now : 0;
  endfunction

  function automatic bit srcHaz(input int d, input int s);
    if (s == 0) return 1'b0;
    if (fwd[d] == 0) return remaining(d, s) != 0;
    return ldTag[d][s] && (remaining(d, s) == LOAD_LAT);
  endfunction

  function automatic bit expStall(input int d, input instrT it);
    int lat;
    bit haz;
    haz = 1'b0;
    if (!it.valid) return 1'b0;
    lat = (it.ins == LW) ? LOAD_LAT : ALU_LAT;
    if (tbReadsRs(it.ins) && srcHaz(d, it.rs)) haz = 1'b1;
    if (tbReadsRt(it.ins) && srcHaz(d, it.rt)) haz = 1'b1;
    if (tbWrites(it.ins) && it.dst != 0 && remaining(d, it.dst) >= lat) haz = 1'b1;
    return haz;
  endfunction

  function automatic logic [31:0] expBusy(input int d);
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (remaining(d, r) != 0);
    return b;
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? prog0.size() : prog1.size();
  endfunction

  function automatic instrT qHead(input int d);
    return (d == 0) ? prog0[0] : prog1[0];
  endfunction

  function automatic void qPop(input int d);
    if (d == 0) void'(prog0.pop_front());
    else        void'(prog1.pop_front());
  endfunction

  function automatic instrT mk(input Instruction ins, input int rs, input int rt, input int dst);
    instrT it;
    it.valid = 1'b1;
    it.ins   = ins;
    it.rs    = rs;
    it.rt    = rt;
    it.dst   = dst;
    return it;
  endfunction

  function automatic void enqueue(input instrT it);
    prog0.push_back(it);
    prog1.push_back(it);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: present each DUT's head instruction, queue expectations, advance the model.
  task automatic applyStimulus(input bit rstIn);
    instrT cur;
    expT   e;
    bit    st;
    int    lat;
    @(posedge clk);
    #1;
    now++;
    rst = rstIn;
    if (rstIn) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 32; r++) begin
          wbCyc[d][r] = 0;
          ldTag[d][r] = 1'b0;
        end
        scModel[d] = 0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      cur = mk(NOP, 0, 0, 0);
      cur.valid = 1'b0;
      if (!rstIn && qSize(d) > 0) cur = qHead(d);
      vld[d]  = cur.valid;
      insD[d] = cur.ins;
      rsD[d]  = 5'(cur.rs);
      rtD[d]  = 5'(cur.rt);
      dstD[d] = 5'(cur.dst);
      st = expStall(d, cur);
      e.d     = d;
      e.stall = st;
      e.busy  = expBusy(d);
      e.pend  = $countones(e.busy);
      e.sc    = scModel[d];
      expQ.push_back(e);
      if (!rstIn) begin
        if (st && scModel[d] < scMax[d]) scModel[d]++;
        if (qSize(d) > 0 && !st) begin
          if (cur.valid && tbWrites(cur.ins) && cur.dst != 0) begin
            lat = (cur.ins == LW) ? LOAD_LAT : ALU_LAT;
            wbCyc[d][cur.dst] = now + 1 + lat;
            ldTag[d][cur.dst] = (cur.ins == LW);
          end
          qPop(d);
        end
      end
    end
  endtask

  task automatic runQueue(input int budget, input string tag);
    int n;
    n = 0;
    while ((qSize(0) > 0 || qSize(1) > 0) && n < budget) begin
      applyStimulus(1'b0);
      n++;
    end
    nAssert++;
    if (qSize(0) > 0 || qSize(1) > 0) begin
      nFail++;
      $display("[TB] FAIL %s drain: %0d/%0d left, required 0/0", tag, qSize(0), qSize(1));
      prog0.delete();
      prog1.delete();
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1);
    applyStimulus(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  task automatic checkStats(input string tag, input int exp0, input int exp1);
    checkOutput({tag, "_sc_f0"}, {60'b0, sc0}, 64'(exp0));
    checkOutput({tag, "_sc_f1"}, {32'b0, sc1}, 64'(exp1));
  endtask

  // Monitor: every queued expectation is compared on the falling edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("stall[%0d]@%0d", e.d, now), {63'b0, stallD[e.d]}, {63'b0, e.stall});
        checkOutput($sformatf("busy[%0d]@%0d", e.d, now), {32'b0, busyD[e.d]}, {32'b0, e.busy});
        checkOutput($sformatf("pend[%0d]@%0d", e.d, now), {58'b0, pendD[e.d]}, 64'(e.pend));
        checkOutput($sformatf("stallcyc[%0d]@%0d", e.d, now),
                    (e.d == 0) ? {60'b0, sc0} : {32'b0, sc1}, 64'(e.sc));
      end
    end
  end

  initial begin
    instrT it;
    int    pick;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; insD[d] = NOP; rsD[d] = '0; rtD[d] = '0; dstD[d] = '0;
    end

    $display("[TB] RAW on ALU result");
    doReset();
    enqueue(mk(ADDU, 1, 2, 3));
    enqueue(mk(ADDU, 3, 3, 4));
    runQueue(50, "alu_raw");
    idle(5);
    checkStats("alu_raw", 3, 0);

    $display("[TB] load-use");
    doReset();
    enqueue(mk(LW, 1, 0, 5));
    enqueue(mk(ADDIU, 5, 0, 6));
    runQueue(50, "load_use");
    idle(5);
    checkStats("load_use", 4, 1);

    $display("[TB] WAW after load");
    doReset();
    enqueue(mk(LW, 1, 0, 7));
    enqueue(mk(ADDU, 1, 2, 7));
    runQueue(50, "waw");
    idle(5);
    checkStats("waw", 2, 2);

    $display("[TB] register zero");
    doReset();
    enqueue(mk(ADDU, 1, 2, 0));
    enqueue(mk(ADDU, 0, 0, 8));
    runQueue(50, "reg0");
    idle(5);
    checkStats("reg0", 0, 0);

    $display("[TB] JAL then JR");
    doReset();
    enqueue(mk(JAL, 0, 0, 31));
    enqueue(mk(JR, 31, 0, 0));
    runQueue(50, "jal_jr");
    idle(5);
    checkStats("jal_jr", 3, 0);

    $display("[TB] stall counter saturation");
    doReset();
    repeat (6) enqueue(mk(LW, 9, 0, 9));
    runQueue(100, "sat");
    idle(5);
    checkStats("sat", 15, 5);

    $display("[TB] reset with writes in flight");
    doReset();
    enqueue(mk(ADDU, 1, 2, 11));
    enqueue(mk(ADDU, 1, 2, 12));
    enqueue(mk(ADDU, 1, 2, 13));
    runQueue(50, "midrst");
    applyStimulus(1'b1);
    #1;
    checkOutput("midrst_busy_f0", {32'b0, busyD[0]}, 64'd0);
    checkOutput("midrst_pend_f0", {58'b0, pendD[0]}, 64'd0);
    checkOutput("midrst_busy_f1", {32'b0, busyD[1]}, 64'd0);
    checkOutput("midrst_pend_f1", {58'b0, pendD[1]}, 64'd0);
    checkStats("midrst", 0, 0);
    applyStimulus(1'b1);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      it.valid = ($urandom_range(0, 4) != 0);
      it.ins   = Instruction'(4'($urandom_range(0, 15)));
      pick = $urandom_range(0, 9);
      it.rs  = (pick == 9) ? 31 : pick;
      pick = $urandom_range(0, 9);
      it.rt  = (pick == 9) ? 31 : pick;
      pick = $urandom_range(0, 9);
      it.dst = (pick == 9) ? 31 : pick;
      enqueue(it);
    end
    for (int k = 0; k < 200; k++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    runQueue(4000, "random");
    idle(6);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
